// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encodings and GF(2^8) helpers for the
// inverse cipher datapath.
package aes_pkg;

  localparam logic [3:0] NR = 4'd10;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_KEYEXP = 3'd1;
  localparam logic [2:0] S_ADDKEY = 3'd2;
  localparam logic [2:0] S_ROUND  = 3'd3;
  localparam logic [2:0] S_FINAL  = 3'd4;

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) r = gmul(r, sq);
      sq = gmul(sq, sq);
    end
    return r;
  endfunction

  // Row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box: inverse affine transform followed by the field inverse.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  logic [7:0] pre;

  always_comb begin
    pre      = {in_byte[6:0], in_byte[7]} ^ {in_byte[4:0], in_byte[7:5]}
             ^ {in_byte[1:0], in_byte[7:2]} ^ 8'h05;
    out_byte = gf_inv(pre);
  end

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box: field inverse followed by the affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  logic [7:0] inv;

  always_comb begin
    inv      = gf_inv(in_byte);
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryption, one round per clock. The key is expanded
// forward to rk10 first, then unwound one round key per cycle.
module aes_inv_cipher
  import aes_pkg::*;
(
  input  logic         AES_clk,
  input  logic         AES_rst,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid,
  output logic         AES_busy
);

  logic [2:0]   state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] st_q, st_d;
  logic [127:0] key_q, key_d;
  logic [127:0] out_q, out_d;
  logic         valid_q, valid_d;

  logic [127:0] isr, isb;
  logic [31:0]  kw0, kw1, kw2, kw3, inv_w3, sub_in, rot_w, sub_w, temp;
  logic [127:0] fwd_key, inv_key;

  assign isr = inv_shift_rows(st_q);

  for (genvar g = 0; g < 16; g++) begin : g_inv_sbox
    aes_inv_sbox u_inv_sbox (
      .in_byte  (isr[127-8*g -: 8]),
      .out_byte (isb[127-8*g -: 8])
    );
  end

  // One S-box word serves both directions: forward needs SubWord(w3),
  // inverse needs SubWord of the recovered w3 = n3 ^ n2.
  always_comb begin
    kw0    = key_q[127:96];
    kw1    = key_q[95:64];
    kw2    = key_q[63:32];
    kw3    = key_q[31:0];
    inv_w3 = kw3 ^ kw2;
    sub_in = (state_q == S_KEYEXP) ? kw3 : inv_w3;
    rot_w  = {sub_in[23:0], sub_in[31:24]};
  end

  for (genvar g = 0; g < 4; g++) begin : g_key_sbox
    aes_sbox u_sbox (
      .in_byte  (rot_w[31-8*g -: 8]),
      .out_byte (sub_w[31-8*g -: 8])
    );
  end

  always_comb begin
    temp       = sub_w ^ {rcon(rnd_q), 24'h000000};
    fwd_key    = '0;
    fwd_key[127:96] = kw0 ^ temp;
    fwd_key[95:64]  = kw1 ^ fwd_key[127:96];
    fwd_key[63:32]  = kw2 ^ fwd_key[95:64];
    fwd_key[31:0]   = kw3 ^ fwd_key[63:32];
    inv_key    = {kw0 ^ temp, kw1 ^ kw0, kw2 ^ kw1, inv_w3};
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    key_d   = key_q;
    out_d   = out_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (AES_en) begin
          st_d    = AES_data_in;
          key_d   = AES_key_in;
          rnd_d   = 4'd1;
          state_d = S_KEYEXP;
        end
      end
      S_KEYEXP: begin
        key_d = fwd_key;
        if (rnd_q == NR) state_d = S_ADDKEY;
        else             rnd_d   = rnd_q + 4'd1;
      end
      S_ADDKEY: begin
        st_d    = st_q ^ key_q;
        key_d   = inv_key;
        rnd_d   = rnd_q - 4'd1;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        st_d  = inv_mix_columns(isb ^ key_q);
        key_d = inv_key;
        rnd_d = rnd_q - 4'd1;
        if (rnd_q == 4'd1) state_d = S_FINAL;
      end
      S_FINAL: begin
        out_d   = isb ^ key_q;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch and
  // every register (including the wide data/key state) is cleared by it.
  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state_q <= S_IDLE;
      rnd_q   <= 4'd0;
      st_q    <= '0;
      key_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
      key_q   <= key_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign AES_data_out       = out_q;
  assign AES_data_out_valid = valid_q;
  assign AES_busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Scoreboard bench for aes_inv_cipher: expected plaintexts and due cycles are
// queued at start, and a negedge monitor pops/compares on each valid pulse.
module tb_aes_inv_cipher;

  logic         AES_clk = 1'b0;
  logic         AES_rst = 1'b0;
  logic         AES_en  = 1'b0;
  logic [127:0] AES_data_in = '0;
  logic [127:0] AES_key_in  = '0;
  logic [127:0] AES_data_out;
  logic         AES_data_out_valid;
  logic         AES_busy;

  aes_inv_cipher dut (
    .AES_clk            (AES_clk),
    .AES_rst            (AES_rst),
    .AES_en             (AES_en),
    .AES_data_in        (AES_data_in),
    .AES_key_in         (AES_key_in),
    .AES_data_out       (AES_data_out),
    .AES_data_out_valid (AES_data_out_valid),
    .AES_busy           (AES_busy)
  );

  always #5 AES_clk = ~AES_clk;

  typedef struct {
    logic [127:0] data;
    int           due;
    string        name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   valid_seen = 0;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  always @(posedge AES_clk) cyc <= cyc + 1;

  // ---------------- reference encryption model ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] tmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      if (a[i]) p = p ^ b;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, a;
    for (int x = 0; x < 256; x++) begin
      a   = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (tmul(a, 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s, t, rk;
    logic [31:0]  w, tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    rk = key;
    rc = 8'h01;
    s  = pt ^ rk;
    for (int r = 1; r <= 10; r++) begin
      for (int k = 0; k < 16; k++) s[127-8*k -: 8] = sbox_t[s[127-8*k -: 8]];
      t = s;
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          s[127-8*(rr+4*c) -: 8] = t[127-8*(rr+4*((c+rr)%4)) -: 8];
      if (r < 10) begin
        t = s;
        for (int c = 0; c < 4; c++) begin
          a0 = t[127-32*c -: 8]; a1 = t[119-32*c -: 8];
          a2 = t[111-32*c -: 8]; a3 = t[103-32*c -: 8];
          s[127-32*c -: 8] = tmul(a0, 8'h02) ^ tmul(a1, 8'h03) ^ a2 ^ a3;
          s[119-32*c -: 8] = a0 ^ tmul(a1, 8'h02) ^ tmul(a2, 8'h03) ^ a3;
          s[111-32*c -: 8] = a0 ^ a1 ^ tmul(a2, 8'h02) ^ tmul(a3, 8'h03);
          s[103-32*c -: 8] = tmul(a0, 8'h03) ^ a1 ^ a2 ^ tmul(a3, 8'h02);
        end
      end
      w   = rk[31:0];
      tmp = {sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]], sbox_t[w[31:24]]}
          ^ {rc, 24'h000000};
      rk[127:96] = rk[127:96] ^ tmp;
      rk[95:64]  = rk[95:64]  ^ rk[127:96];
      rk[63:32]  = rk[63:32]  ^ rk[95:64];
      rk[31:0]   = rk[31:0]   ^ rk[63:32];
      rc = tmul(rc, 8'h02);
      s  = s ^ rk;
    end
    return s;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge AES_clk);
      if (AES_data_out_valid === 1'b1) begin
        valid_seen++;
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_valid: valid at cycle %0d with nothing expected, data=%h", cyc, AES_data_out);
        end else begin
          e = sb_q.pop_front();
          if (AES_data_out !== e.data) begin
            tests_failed++;
            $display("FAIL %s_data: got %h expected %h", e.name, AES_data_out, e.data);
          end
          tests_run++;
          if (cyc !== e.due) begin
            tests_failed++;
            $display("FAIL %s_latency: valid at cycle %0d expected %0d", e.name, cyc, e.due);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  // Called on a negedge; the next posedge is E0.
  task automatic start(input logic [127:0] d, input logic [127:0] k,
                       input logic [127:0] pt, input string nm);
    exp_t e;
    AES_en      = 1'b1;
    AES_data_in = d;
    AES_key_in  = k;
    e.data = pt;
    e.due  = cyc + 22;
    e.name = nm;
    sb_q.push_back(e);
    @(negedge AES_clk);
    AES_en      = 1'b0;
    AES_data_in = $urandom();
    AES_key_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 80 && sb_q.size() != 0; i++) @(negedge AES_clk);
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_timeout: %0d results still pending, required 0", nm, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge AES_clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    AES_rst = 1'b1;
    idle_cycles(2);
    AES_rst = 1'b0;
    @(negedge AES_clk);
    tests_run++;
    if (AES_data_out !== 128'h0) begin
      tests_failed++; $display("FAIL reset_data: got %h required 0", AES_data_out);
    end
    tests_run++;
    if (AES_data_out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid: got %b required 0", AES_data_out_valid);
    end
    tests_run++;
    if (AES_busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy: got %b required 0", AES_busy);
    end
  endtask

  task automatic test_fips_c1();
    start(CT_C1, KEY_C1, PT_C1, "c1");
    tests_run++;
    if (AES_busy !== 1'b1) begin
      tests_failed++; $display("FAIL c1_busy: got %b required 1", AES_busy);
    end
    wait_drain("c1");
    idle_cycles(5);
    tests_run++;
    if (AES_data_out !== PT_C1) begin
      tests_failed++; $display("FAIL c1_hold: got %h required %h", AES_data_out, PT_C1);
    end
    tests_run++;
    if (AES_busy !== 1'b0) begin
      tests_failed++; $display("FAIL c1_idle_busy: got %b required 0", AES_busy);
    end
  endtask

  task automatic test_fips_b();
    start(CT_B, KEY_B, PT_B, "fips_b");
    wait_drain("fips_b");
    idle_cycles(2);
  endtask

  task automatic test_round_trip();
    logic [127:0] pt, key;
    pt  = 128'h000000d1_00000000_00000000_00000000;
    key = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
    start(encrypt(pt, key), key, pt, "round_trip");
    wait_drain("round_trip");
    idle_cycles(2);
  endtask

  task automatic test_busy_reject();
    int e0, v0;
    v0 = valid_seen;
    e0 = cyc + 1;
    start(CT_C1, KEY_C1, PT_C1, "busy_c1");
    while (cyc < e0 + 4) @(negedge AES_clk);
    AES_en      = 1'b1;
    AES_data_in = CT_B;
    AES_key_in  = KEY_B;
    @(negedge AES_clk);
    AES_en = 1'b0;
    wait_drain("busy_c1");
    idle_cycles(30);
    tests_run++;
    if (valid_seen - v0 != 1) begin
      tests_failed++; $display("FAIL busy_pulses: got %0d valid pulses required 1", valid_seen - v0);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pts [23];
    logic [127:0] cts [23];
    exp_t e;
    int e0;
    for (int i = 0; i < 23; i++) begin
      pts[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      cts[i] = encrypt(pts[i], KEY_C1);
    end
    e0 = cyc + 1;
    AES_key_in = KEY_C1;
    for (int i = 0; i < 23; i++) begin
      AES_en      = 1'b1;
      AES_data_in = cts[i];
      if (i == 0 || i == 22) begin
        e.data = pts[i];
        e.due  = e0 + i + 21;
        e.name = (i == 0) ? "b2b_first" : "b2b_second";
        sb_q.push_back(e);
      end
      @(negedge AES_clk);
    end
    AES_en = 1'b0;
    wait_drain("b2b");
    idle_cycles(3);
  endtask

  task automatic test_reset_midop();
    int e0, v0;
    e0 = cyc + 1;
    start(CT_C1, KEY_C1, PT_C1, "midop");
    while (cyc < e0 + 9) @(negedge AES_clk);
    AES_rst = 1'b1;
    v0 = valid_seen;
    sb_q.delete();
    @(negedge AES_clk);
    AES_rst = 1'b0;
    tests_run++;
    if (AES_data_out !== 128'h0) begin
      tests_failed++; $display("FAIL midop_data: got %h required 0", AES_data_out);
    end
    tests_run++;
    if (AES_busy !== 1'b0) begin
      tests_failed++; $display("FAIL midop_busy: got %b required 0", AES_busy);
    end
    idle_cycles(30);
    tests_run++;
    if (valid_seen != v0) begin
      tests_failed++; $display("FAIL midop_valid: got %0d pulses after reset required 0", valid_seen - v0);
    end
    start(CT_C1, KEY_C1, PT_C1, "midop_fresh");
    wait_drain("midop_fresh");
  endtask

  initial begin
    build_sbox();
    @(negedge AES_clk);
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_round_trip();
    test_busy_reject();
    test_back_to_back();
    test_reset_midop();
    idle_cycles(3);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
